output_store_unit: RTL and testbench

Result-drain engine on the responder side of the controller's STORE handshake. When `store_en` rises, it snapshots the systolic array's ROWS×COLS accumulator outputs and requantizes each one to OUT_W bits with an arithmetic shift and saturation. It writes the results row-major into output SRAM through a valid/ready write port, then returns a one-cycle `store_done` pulse so the controller can advance to FINISH.

---
 rtl/output_store_unit.sv | 151 +++++++++++++++
 tb/tb_output_store_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_store_unit.sv
// output_store_unit: drains the systolic array's accumulators into output SRAM.
// On a STORE request the accumulators are snapshotted, requantized (arithmetic
// shift + saturation) and written row-major through a valid/ready port, then a
// one-cycle store_done pulse is returned to the controller.
module output_store_unit #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 0,
  parameter int ADDR_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        store_en,
  input  logic [ROWS*COLS*ACC_W-1:0]  acc_flat,
  input  logic                        sram_ready,
  output logic                        sram_we,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [OUT_W-1:0]            sram_wdata,
  output logic                        store_done,
  output logic                        busy
);

  localparam int N = ROWS * COLS;
  localparam logic [ADDR_W-1:0]       LAST_IDX = ADDR_W'(N - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN  = ~OUT_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE,
    S_HOLD
  } state_t;

  state_t                   r_state;
  logic [ADDR_W-1:0]        r_idx;
  logic                     r_we;
  logic [OUT_W-1:0]         r_wdata;
  logic                     r_done;
  logic                     r_busy;
  logic signed [ACC_W-1:0]  r_snap [N];

  logic [ADDR_W-1:0]        w_next_idx;
  logic [OUT_W-1:0]         w_next_wdata;
  logic [OUT_W-1:0]         w_first_wdata;
  logic                     w_capture;

  // Shift right keeping the sign, then clamp into the signed OUT_W range.
  function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] y;
    y = x >>> SHIFT;
    if (y > OUT_MAX)      requant = OUT_MAX[OUT_W-1:0];
    else if (y < OUT_MIN) requant = OUT_MIN[OUT_W-1:0];
    else                  requant = y[OUT_W-1:0];
  endfunction

  assign w_capture = (r_state == S_IDLE) && store_en;

  // Next-element data path: element 0 comes from the live bus at capture time
  // (identical to what is being snapshotted), the rest from the snapshot.
  always_comb begin
    w_next_idx    = r_idx + 1'b1;
    w_next_wdata  = requant(r_snap[w_next_idx]);
    w_first_wdata = requant(acc_flat[ACC_W-1:0]);
  end

  // Snapshot of every accumulator, taken on the request edge.
  // NOTE: pure data storage, qualified by w_capture, so it carries no reset;
  // nothing reads it before the first capture writes it.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < N; i++) begin
        r_snap[i] <= acc_flat[i*ACC_W +: ACC_W];
      end
    end
  end

  // Transfer FSM with registered write-port, done and busy outputs.
  // NOTE: every state element here uses <= so all updates of one edge see
  // the same pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (store_en) begin
            r_state <= S_WRITE;
            r_idx   <= '0;
            r_we    <= 1'b1;
            r_wdata <= w_first_wdata;
            r_busy  <= 1'b1;
          end
        end
        S_WRITE: begin
          if (!store_en) begin
            // Abort: already-accepted writes stay in SRAM, no done pulse.
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (sram_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state <= S_DONE;
              r_we    <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= w_next_idx;
              r_wdata <= w_next_wdata;
            end
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          if (store_en) begin
            r_state <= S_HOLD;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_HOLD: begin
          // Wait for the request to drop so a held store_en cannot retrigger.
          if (!store_en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sram_we    = r_we;
  assign sram_addr  = r_idx;
  assign sram_wdata = r_wdata;
  assign store_done = r_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_output_store_unit.sv
// Directed bench for output_store_unit. Two instances share all inputs:
// dut uses SHIFT=8, dut0 uses SHIFT=0. Inputs change and outputs are
// observed on the falling clock edge.
module tb_output_store_unit;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int ACC_W  = 16;
  localparam int OUT_W  = 8;
  localparam int ADDR_W = 4;
  localparam int N      = ROWS * COLS;

  logic                       clk;
  logic                       rst_n;
  logic                       store_en;
  logic [N*ACC_W-1:0]         acc_flat;
  logic                       sram_ready;

  logic                       sram_we;
  logic [ADDR_W-1:0]          sram_addr;
  logic [OUT_W-1:0]           sram_wdata;
  logic                       store_done;
  logic                       busy;

  logic                       s0_we;
  logic [ADDR_W-1:0]          s0_addr;
  logic [OUT_W-1:0]           s0_wdata;
  logic                       s0_done;
  logic                       s0_busy;

  int checks;
  int failures;

  // Observation record of one transfer.
  int         n_obs;
  int         n_done;
  int         done_cyc;
  int         overlap;
  int         obs_addr  [64];
  logic [7:0] obs_data  [64];
  logic [7:0] obs_data0 [64];
  logic       obs_rdy   [64];

  output_store_unit #(
    .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(8), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .store_en(store_en), .acc_flat(acc_flat),
    .sram_ready(sram_ready), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .store_done(store_done), .busy(busy)
  );

  output_store_unit #(
    .ROWS(ROWS), .COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(0), .ADDR_W(ADDR_W)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .store_en(store_en), .acc_flat(acc_flat),
    .sram_ready(sram_ready), .sram_we(s0_we), .sram_addr(s0_addr),
    .sram_wdata(s0_wdata), .store_done(s0_done), .busy(s0_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element i = base + step*i.
  task automatic set_acc_ramp(input int base, input int step);
    for (int i = 0; i < N; i++) acc_flat[i*ACC_W +: ACC_W] = 16'(base + step * i);
  endtask

  task automatic go_idle();
    store_en   = 1'b0;
    sram_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Raise store_en and watch 40 cycles; cycle c observes the state after
  // edge k+c-1. Optionally stalls at one address and scrambles acc_flat.
  task automatic run_transfer(input int stall_addr, input int stall_n, input bit mutate);
    int stalls;
    n_obs = 0; n_done = 0; done_cyc = -1; overlap = 0;
    stalls = stall_n;
    store_en = 1'b1;
    sram_ready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if ((sram_we && store_done) || (s0_we && s0_done)) overlap++;
      if (store_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (sram_we && int'(sram_addr) == stall_addr && stalls > 0) begin
        sram_ready = 1'b0;
        stalls--;
      end else begin
        sram_ready = 1'b1;
      end
      if (sram_we && n_obs < 64) begin
        obs_addr[n_obs]  = int'(sram_addr);
        obs_data[n_obs]  = sram_wdata;
        obs_data0[n_obs] = s0_wdata;
        obs_rdy[n_obs]   = sram_ready;
        n_obs++;
      end
      if (mutate) set_acc_ramp(c * 1237 + 5, 3001);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; store_en = 1'b0; sram_ready = 1'b1; acc_flat = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sram_we, sram_addr, sram_wdata, store_done, busy} !== '0) begin
      failures++;
      $display("FAIL reset_during we=%b addr=%0d wdata=%h done=%b busy=%b exp all 0",
               sram_we, sram_addr, sram_wdata, store_done, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({sram_we, sram_addr, sram_wdata, store_done, busy, s0_we, s0_busy} !== '0) begin
      failures++;
      $display("FAIL reset_after we=%b addr=%0d wdata=%h done=%b busy=%b exp all 0",
               sram_we, sram_addr, sram_wdata, store_done, busy);
    end
    begin
      int act;
      act = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (sram_we || busy || store_done) act++;
      end
      checks++;
      if (act !== 0) begin
        failures++;
        $display("FAIL idle_quiet active_cycles=%0d exp 0", act);
      end
    end
  endtask

  task automatic test_nominal();
    set_acc_ramp(0, 256);
    run_transfer(-1, 0, 1'b0);
    checks++;
    if (n_obs !== N) begin
      failures++; $display("FAIL nominal_writes got=%0d exp=%0d", n_obs, N);
    end
    for (int i = 0; i < N && i < n_obs; i++) begin
      checks++;
      if (obs_addr[i] !== i || obs_data[i] !== 8'(i)) begin
        failures++;
        $display("FAIL nominal_elem%0d addr=%0d data=%h exp addr=%0d data=%h",
                 i, obs_addr[i], obs_data[i], i, 8'(i));
      end
    end
    checks++;
    if (n_done !== 1 || done_cyc !== N + 1) begin
      failures++;
      $display("FAIL nominal_done pulses=%0d cycle=%0d exp 1 at %0d", n_done, done_cyc, N + 1);
    end
    checks++;
    if (overlap !== 0) begin
      failures++; $display("FAIL nominal_overlap got=%0d exp=0", overlap);
    end
    checks++;
    if (busy !== 1'b1 || sram_we !== 1'b0) begin
      failures++; $display("FAIL nominal_hold busy=%b we=%b exp busy=1 we=0", busy, sram_we);
    end
    store_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL nominal_idle busy=%b exp 0", busy);
    end
    go_idle();
  endtask

  task automatic test_saturation();
    logic [7:0] exp0 [9];
    logic [7:0] exp8 [9];
    int         vals [9];
    vals = '{32767, -32768, -1, 100, 200, -200, 127, -128, 128};
    exp0 = '{8'h7F, 8'h80, 8'hFF, 8'h64, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F};
    exp8 = '{8'h7F, 8'h80, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    acc_flat = '0;
    for (int i = 0; i < 9; i++) acc_flat[i*ACC_W +: ACC_W] = 16'(vals[i]);
    run_transfer(-1, 0, 1'b0);
    for (int i = 0; i < 9 && i < n_obs; i++) begin
      checks++;
      if (obs_data0[i] !== exp0[i] || obs_data[i] !== exp8[i]) begin
        failures++;
        $display("FAIL sat_elem%0d shift0=%h shift8=%h exp shift0=%h shift8=%h",
                 i, obs_data0[i], obs_data[i], exp0[i], exp8[i]);
      end
    end
    checks++;
    if (n_obs !== N || n_done !== 1) begin
      failures++; $display("FAIL sat_count writes=%0d dones=%0d exp %0d and 1", n_obs, n_done, N);
    end
    go_idle();
  endtask

  task automatic test_backpressure();
    int acc_n;
    int stall_n;
    int stall_bad;
    int seq_bad;
    set_acc_ramp(0, 256);
    run_transfer(5, 3, 1'b0);
    acc_n = 0; stall_n = 0; stall_bad = 0; seq_bad = 0;
    for (int i = 0; i < n_obs; i++) begin
      if (obs_rdy[i]) begin
        if (obs_addr[i] !== acc_n || obs_data[i] !== 8'(acc_n)) seq_bad++;
        acc_n++;
      end else begin
        stall_n++;
        if (obs_addr[i] !== 5 || obs_data[i] !== 8'h05) stall_bad++;
      end
    end
    checks++;
    if (acc_n !== N || seq_bad !== 0) begin
      failures++; $display("FAIL bp_sequence accepted=%0d bad=%0d exp %0d and 0", acc_n, seq_bad, N);
    end
    checks++;
    if (stall_n !== 3 || stall_bad !== 0) begin
      failures++; $display("FAIL bp_stall stalled=%0d unstable=%0d exp 3 and 0", stall_n, stall_bad);
    end
    checks++;
    if (n_done !== 1 || done_cyc !== N + 4) begin
      failures++;
      $display("FAIL bp_done pulses=%0d cycle=%0d exp 1 at %0d", n_done, done_cyc, N + 4);
    end
    go_idle();
  endtask

  task automatic test_abort_restart();
    bit found;
    int dones;
    set_acc_ramp(0, 256);
    store_en = 1'b1; sram_ready = 1'b1; found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (sram_we && sram_addr == 4'd4) begin
        store_en = 1'b0; sram_ready = 1'b0; found = 1'b1;
      end
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL abort_reach addr4 seen=0 exp 1");
    end
    @(negedge clk);
    checks++;
    if (sram_we !== 1'b0 || busy !== 1'b0 || store_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_stop we=%b busy=%b done=%b exp 0 0 0", sram_we, busy, store_done);
    end
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (store_done || sram_we) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++; $display("FAIL abort_quiet active=%0d exp 0", dones);
    end
    set_acc_ramp(15 * 256, -256);
    run_transfer(-1, 0, 1'b0);
    checks++;
    if (n_obs !== N || n_done !== 1 || done_cyc !== N + 1) begin
      failures++;
      $display("FAIL restart_count writes=%0d dones=%0d cycle=%0d exp %0d 1 %0d",
               n_obs, n_done, done_cyc, N, N + 1);
    end
    for (int i = 0; i < N && i < n_obs; i += 5) begin
      checks++;
      if (obs_addr[i] !== i || obs_data[i] !== 8'(15 - i)) begin
        failures++;
        $display("FAIL restart_elem%0d addr=%0d data=%h exp addr=%0d data=%h",
                 i, obs_addr[i], obs_data[i], i, 8'(15 - i));
      end
    end
    go_idle();
  endtask

  task automatic test_snapshot();
    int bad;
    set_acc_ramp(16 * 256, 256);
    run_transfer(-1, 0, 1'b1);
    bad = 0;
    for (int i = 0; i < n_obs; i++) begin
      if (obs_addr[i] !== i || obs_data[i] !== 8'(i + 16)) bad++;
    end
    checks++;
    if (n_obs !== N || bad !== 0) begin
      failures++; $display("FAIL snapshot writes=%0d wrong=%0d exp %0d and 0", n_obs, bad, N);
    end
    go_idle();
  endtask

  task automatic test_reset_midtransfer();
    int dones;
    set_acc_ramp(0, 256);
    store_en = 1'b1; sram_ready = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (sram_we !== 1'b1 || sram_addr !== 4'd5) begin
      failures++; $display("FAIL midreset_pre we=%b addr=%0d exp 1 5", sram_we, sram_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sram_we, sram_addr, sram_wdata, store_done, busy} !== '0) begin
      failures++;
      $display("FAIL midreset_async we=%b addr=%0d wdata=%h done=%b busy=%b exp all 0",
               sram_we, sram_addr, sram_wdata, store_done, busy);
    end
    store_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (store_done || sram_we || busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++; $display("FAIL midreset_quiet active=%0d exp 0", dones);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_nominal();
    test_saturation();
    test_backpressure();
    test_abort_restart();
    test_snapshot();
    test_reset_midtransfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
